// File: rtl/demo_pkg.sv
// rtl/demo_pkg.sv - shared types and constants for the scene sequencer
package demo_pkg;

  typedef enum logic {
    SHOW  = 1'b0,
    BLANK = 1'b1
  } scene_state_t;

  localparam int SCENE_W  = 8;
  localparam int SCROLL_W = 10;
  localparam int COLOR_W  = 6;

  // {R,G,B} 2:2:2 entries, stepped once per full pass through the scenes
  localparam logic [COLOR_W-1:0] PALETTE [4] = '{
    6'b110000, 6'b001100, 6'b000011, 6'b111111
  };

endpackage

// File: rtl/scene_sequencer_if.sv
// rtl/scene_sequencer_if.sv - timing-in / pixel-stage-out signal bundle
interface scene_sequencer_if;

  logic                          vsync;
  logic                          pause;
  logic                          skip;
  logic [demo_pkg::SCENE_W-1:0]  background_state;
  logic [demo_pkg::COLOR_W-1:0]  solid_color;
  logic [demo_pkg::SCROLL_W-1:0] moving_counter;
  logic                          blank;
  logic                          frame_tick;

  modport master (
    input  vsync, pause, skip,
    output background_state, solid_color, moving_counter, blank, frame_tick
  );

  modport slave (
    output vsync, pause, skip,
    input  background_state, solid_color, moving_counter, blank, frame_tick
  );

endinterface

// File: rtl/edge_detect.sv
// rtl/edge_detect.sv - registered input plus registered rising-edge pulse
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic din_q;
  logic armed;

  // armed keeps a level already high at reset release from looking like an edge
  always_ff @(posedge clk) begin
    if (rst) begin
      din_q <= 1'b0;
      armed <= 1'b0;
      pulse <= 1'b0;
    end else begin
      din_q <= din;
      armed <= 1'b1;
      pulse <= armed & din & ~din_q;
    end
  end

endmodule

// File: rtl/scene_sequencer.sv
// rtl/scene_sequencer.sv - frame-rate scene stepper with inter-scene blanking
module scene_sequencer
  import demo_pkg::*;
#(
  parameter int FRAMES_PER_SCENE = 120,
  parameter int BLANK_FRAMES     = 8,
  parameter int NUM_SCENES       = 12
) (
  input logic            clk,
  input logic            rst,
  scene_sequencer_if.master bus
);

  localparam int MAX_DWELL = (FRAMES_PER_SCENE > BLANK_FRAMES) ? FRAMES_PER_SCENE : BLANK_FRAMES;
  localparam int DW        = (MAX_DWELL > 1) ? $clog2(MAX_DWELL) : 1;

  localparam logic [DW-1:0]      SHOW_LAST  = DW'(FRAMES_PER_SCENE - 1);
  localparam logic [DW-1:0]      BLANK_LAST = DW'(BLANK_FRAMES - 1);
  localparam logic [SCENE_W-1:0] SCENE_LAST = SCENE_W'(NUM_SCENES - 1);

  scene_state_t          state_q, state_d;
  logic [DW-1:0]         dwell_q, dwell_d;
  logic [SCENE_W-1:0]    scene_q, scene_d;
  logic [1:0]            pal_q, pal_d;
  logic [SCROLL_W-1:0]   mc_q, mc_d;
  logic                  advance;
  logic                  tick;
  logic                  skip_edge;

  edge_detect u_vsync_edge (.clk(clk), .rst(rst), .din(bus.vsync), .pulse(tick));
  edge_detect u_skip_edge  (.clk(clk), .rst(rst), .din(bus.skip),  .pulse(skip_edge));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SHOW;
      dwell_q <= '0;
      scene_q <= '0;
      pal_q   <= '0;
      mc_q    <= '0;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
      scene_q <= scene_d;
      pal_q   <= pal_d;
      mc_q    <= mc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    scene_d = scene_q;
    pal_d   = pal_q;
    mc_d    = mc_q;
    advance = 1'b0;

    case (state_q)
      SHOW: begin
        // skip takes precedence over pause and absorbs a coincident final tick
        if (skip_edge) begin
          advance = 1'b1;
        end else if (tick && !bus.pause) begin
          if (dwell_q == SHOW_LAST) begin
            advance = 1'b1;
          end else begin
            dwell_d = dwell_q + 1'b1;
            mc_d    = mc_q + 1'b1;
          end
        end
      end
      BLANK: begin
        if (tick) begin
          if (dwell_q == BLANK_LAST) begin
            state_d = SHOW;
            dwell_d = '0;
          end else begin
            dwell_d = dwell_q + 1'b1;
          end
        end
      end
      default: state_d = SHOW;
    endcase

    // scene steps on blank entry so the new mode is settled before blank falls
    if (advance) begin
      state_d = BLANK;
      dwell_d = '0;
      mc_d    = '0;
      if (scene_q == SCENE_LAST) begin
        scene_d = '0;
        pal_d   = pal_q + 1'b1;
      end else begin
        scene_d = scene_q + 1'b1;
      end
    end
  end

  assign bus.background_state = scene_q;
  assign bus.solid_color      = PALETTE[pal_q];
  assign bus.moving_counter   = mc_q;
  assign bus.blank            = (state_q == BLANK);
  assign bus.frame_tick       = tick;

endmodule

// File: tb/tb_scene_sequencer.sv
// tb/tb_scene_sequencer.sv - randomized bench for scene_sequencer against a frame-level model
module tb_scene_sequencer;

  localparam int F = 4;
  localparam int B = 2;
  localparam int N = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  scene_sequencer_if bus ();

  scene_sequencer #(
    .FRAMES_PER_SCENE(F),
    .BLANK_FRAMES    (B),
    .NUM_SCENES      (N)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [5:0] exp_pal [4] = '{6'b110000, 6'b001100, 6'b000011, 6'b111111};

  int m_scene;
  int m_pal;
  int m_mc;
  int m_left;
  bit m_blank;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function void m_reset();
    m_scene = 0;
    m_pal   = 0;
    m_mc    = 0;
    m_left  = F;
    m_blank = 0;
  endfunction

  function void m_advance();
    m_blank = 1;
    m_left  = B;
    m_mc    = 0;
    m_scene = (m_scene + 1) % N;
    if (m_scene == 0) m_pal = (m_pal + 1) % 4;
  endfunction

  // m_left counts frames still to show (or blank) in the current phase
  function void m_frame(input bit p, input bit s);
    if (!m_blank && s) begin
      m_advance();
    end else if (m_blank) begin
      m_left--;
      if (m_left == 0) begin
        m_blank = 0;
        m_left  = F;
      end
    end else if (!p) begin
      m_left--;
      if (m_left == 0) m_advance();
      else m_mc = (m_mc + 1) % 1024;
    end
  endfunction

  task automatic compare_all(input string tag);
    check({tag, "/scene"}, bus.background_state, m_scene);
    check({tag, "/color"}, bus.solid_color, exp_pal[m_pal]);
    check({tag, "/scroll"}, bus.moving_counter, m_mc);
    check({tag, "/blank"}, bus.blank, m_blank);
  endtask

  task automatic frame(input bit p, input bit s, input string tag);
    @(negedge clk);
    bus.vsync = 1'b1;
    bus.pause = p;
    bus.skip  = s;
    @(negedge clk);
    bus.vsync = 1'b0;
    bus.skip  = 1'b0;
    check({tag, "/tick"}, bus.frame_tick, 1);
    @(negedge clk);
    check({tag, "/tick_off"}, bus.frame_tick, 0);
    m_frame(p, s);
    compare_all(tag);
  endtask

  initial begin
    bus.vsync = 1'b0;
    bus.pause = 1'b0;
    bus.skip  = 1'b0;
    rst       = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    m_reset();
    compare_all("reset");
    check("reset/tick", bus.frame_tick, 0);

    for (int i = 0; i < F + B; i++) frame(1'b0, 1'b0, "boot");

    // held skip mid-scene: one advance, two cycles after the rise
    frame(1'b0, 1'b0, "pre_skip");
    @(negedge clk);
    bus.skip = 1'b1;
    @(negedge clk);
    check("skip_lat1/blank", bus.blank, 0);
    @(negedge clk);
    m_advance();
    compare_all("skip_lat2");
    repeat (48) @(negedge clk);
    compare_all("skip_held");
    bus.skip = 1'b0;
    @(negedge clk);
    bus.skip = 1'b1;
    repeat (3) @(negedge clk);
    compare_all("skip_in_blank");
    bus.skip = 1'b0;
    for (int i = 0; i < B; i++) frame(1'b0, 1'b0, "skip_blank_end");

    for (int k = 0; k < 40 && !(m_scene == 0 && !m_blank && m_left == F); k++)
      frame(1'b0, 1'b0, "to_scene0");
    check("to_scene0/found", (m_scene == 0 && !m_blank), 1);
    frame(1'b0, 1'b0, "pre_pause");
    frame(1'b0, 1'b0, "pre_pause");
    for (int i = 0; i < 10; i++) frame(1'b1, 1'b0, "paused");
    frame(1'b0, 1'b0, "unpaused");
    frame(1'b0, 1'b0, "unpaused_adv");

    for (int k = 0; k < 40 && !(!m_blank && m_left == F); k++) frame(1'b0, 1'b0, "to_start");
    for (int i = 0; i < F - 1; i++) frame(1'b0, 1'b0, "pre_simul");
    frame(1'b0, 1'b1, "simul");

    for (int i = 0; i < 4 * N * (F + B); i++) frame(1'b0, 1'b0, "wraps");

    for (int i = 0; i < 120; i++)
      frame($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, "rand");

    for (int k = 0; k < 40 && !(m_blank && m_scene == 2); k++) frame(1'b0, 1'b0, "to_blank2");
    check("to_blank2/found", (m_blank && m_scene == 2), 1);
    @(negedge clk);
    rst       = 1'b1;
    bus.vsync = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    m_reset();
    compare_all("mid_rst");
    check("mid_rst/tick", bus.frame_tick, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("mid_rst/no_tick", bus.frame_tick, 0);
    end
    bus.vsync = 1'b0;
    @(negedge clk);
    frame(1'b0, 1'b0, "post_rst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
